sram_port_ctrl: RTL

Initiator-side controller for the `sram_4kb_256x128x8` macro. It turns a valid/ready request stream (reads and writes) into correctly sequenced macro pin activity, captures read data after a configurable latency, and returns it on a valid/ready response channel. It sits between the convolution datapath and the SRAM macro, replacing ad-hoc pin driving. It can optionally zero-fill the whole array after reset.

---
 rtl/sram_port_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sram_port_ctrl.sv
// Initiator-side controller for the sram_4kb_256x128x8 macro: sequences macro pins
// from a valid/ready request stream and returns read data on a valid/ready response.
module sram_port_ctrl #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 8,
  parameter int READ_LAT       = 1,
  parameter int WR_RECOVERY    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic              busy,
  output logic              sram_write_en,
  output logic              sram_sense_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  localparam int CNT_MAX = (READ_LAT > WR_RECOVERY) ? READ_LAT : WR_RECOVERY;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_WRITE, S_WREC, S_READ, S_RWAIT, S_RESP
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   clr_cnt;
  logic [CNT_W-1:0]  wait_cnt;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      init_done     <= (CLEAR_ON_RESET == 0);
      clr_cnt       <= '0;
      wait_cnt      <= '0;
      sram_write_en <= 1'b0;
      sram_sense_en <= 1'b1;
      sram_addr     <= '0;
      sram_din      <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
    end else begin
      case (state)
        // Clear counter carries one extra bit so termination is seen on the MSB, never a wrap.
        S_CLEAR: begin
          if (clr_cnt[ADDR_W]) begin
            sram_write_en <= 1'b0;
            sram_sense_en <= 1'b1;
            init_done     <= 1'b1;
            state         <= S_IDLE;
          end else begin
            sram_write_en <= 1'b1;
            sram_sense_en <= 1'b1;
            sram_addr     <= clr_cnt[ADDR_W-1:0];
            sram_din      <= '0;
            clr_cnt       <= clr_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (req_valid) begin
            sram_addr <= req_addr;
            if (req_we) begin
              sram_din      <= req_wdata;
              sram_write_en <= 1'b1;
              state         <= S_WRITE;
            end else begin
              sram_sense_en <= 1'b0;
              state         <= S_READ;
            end
          end
        end
        S_WRITE: begin
          sram_write_en <= 1'b0;
          if (WR_RECOVERY > 0) begin
            wait_cnt <= CNT_W'(WR_RECOVERY);
            state    <= S_WREC;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WREC: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == CNT_W'(1)) state <= S_IDLE;
        end
        S_READ: begin
          wait_cnt <= CNT_W'(READ_LAT);
          state    <= S_RWAIT;
        end
        // Address and sense_en stay put until the edge that samples the macro output.
        S_RWAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == CNT_W'(1)) begin
            rsp_rdata     <= sram_dout;
            rsp_valid     <= 1'b1;
            sram_sense_en <= 1'b1;
            state         <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
